fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 110 +++++++++++
 tb/tb_fifo_wr_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: four requesters share one FIFO write port,
// each grant covering up to burst_len beats, with one idle arbitration cycle between grants.
module fifo_wr_arb #(
  parameter int data_width = 8,
  parameter int burst_len  = 4
) (
  input  logic                      w_clk,
  input  logic                      wrst,
  input  logic [3:0]                req_valid,
  input  logic [4*data_width-1:0]   req_data,
  output logic [3:0]                req_ready,
  output logic [3:0]                gnt,
  input  logic                      full,
  output logic                      w_en,
  output logic [data_width-1:0]     data_in
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t      state_q;
  logic [1:0]  rr_ptr_q;
  logic [1:0]  owner_q;
  logic [3:0]  beat_cnt_q;
  logic [3:0]  gnt_q;

  logic [7:0]  rot_dbl;
  logic [3:0]  rot;
  logic [1:0]  pick_off;
  logic [1:0]  pick;
  logic [1:0]  rr_ptr_d;
  logic        owner_vld;
  logic        in_burst;
  logic        xfer;
  logic        last_beat;

  // Rotate the request vector so rr_ptr sits at bit 0; the lowest set bit
  // of the rotated vector is then the next index in round-robin order.
  always_comb begin
    rot_dbl = {req_valid, req_valid} >> rr_ptr_q;
    rot     = rot_dbl[3:0];
    if (rot[0])      pick_off = 2'd0;
    else if (rot[1]) pick_off = 2'd1;
    else if (rot[2]) pick_off = 2'd2;
    else             pick_off = 2'd3;
    pick = rr_ptr_q + pick_off;
  end

  assign in_burst  = (state_q == BURST) && !wrst;
  assign owner_vld = req_valid[owner_q];
  assign xfer      = in_burst && owner_vld && !full;
  assign last_beat = (beat_cnt_q == 4'(burst_len - 1));
  assign rr_ptr_d  = owner_q + 2'd1;

  always_comb begin
    req_ready = 4'b0000;
    w_en      = 1'b0;
    data_in   = req_data[32'(owner_q) * data_width +: data_width];
    if (in_burst) begin
      req_ready[owner_q] = ~full;
      w_en               = owner_vld & ~full;
    end
  end

  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd0;
      owner_q    <= 2'd0;
      beat_cnt_q <= 4'd0;
      gnt_q      <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            state_q    <= BURST;
            owner_q    <= pick;
            gnt_q      <= 4'b0001 << pick;
            beat_cnt_q <= 4'd0;
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_beat) begin
              state_q  <= IDLE;
              gnt_q    <= 4'b0000;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end
          end else if (!owner_vld) begin
            // Owner ran dry: give the port up rather than hold it idle.
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus randomized traffic against a
// grant-level reference model (owner index, beats taken, next search start).
module tb_fifo_wr_arb;
  localparam int DW = 8;
  localparam int BL = 4;

  logic            w_clk = 1'b0;
  logic            wrst  = 1'b1;
  logic [3:0]      req_valid = 4'b0000;
  logic [4*DW-1:0] req_data  = '0;
  logic [3:0]      req_ready;
  logic [3:0]      gnt;
  logic            full = 1'b0;
  logic            w_en;
  logic [DW-1:0]   data_in;

  int errors = 0;
  int checks = 0;

  fifo_wr_arb #(.data_width(DW), .burst_len(BL)) dut (
    .w_clk     (w_clk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gnt       (gnt),
    .full      (full),
    .w_en      (w_en),
    .data_in   (data_in)
  );

  always #5 w_clk = ~w_clk;

  // Reference model: who owns the port (-1 = nobody), beats written so far,
  // and where the next round-robin search begins.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;

  always @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      m_owner <= -1;
      m_beats <= 0;
      m_ptr   <= 0;
    end else if (m_owner < 0) begin
      if (req_valid != 4'b0000) begin
        for (int k = 3; k >= 0; k--)
          if (req_valid[(m_ptr + k) % 4]) m_owner <= (m_ptr + k) % 4;
        m_beats <= 0;
      end
    end else if (req_valid[m_owner] && !full) begin
      if (m_beats + 1 == BL) begin
        m_owner <= -1;
        m_ptr   <= (m_owner + 1) % 4;
      end else begin
        m_beats <= m_beats + 1;
      end
    end else if (!req_valid[m_owner]) begin
      m_owner <= -1;
      m_ptr   <= (m_owner + 1) % 4;
    end
  end

  function automatic logic [3:0] exp_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_ready();
    return (!wrst && m_owner >= 0 && !full) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic exp_wen();
    return !wrst && m_owner >= 0 && req_valid[m_owner] && !full;
  endfunction

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    req_valid = 4'b0000;
    full = 1'b0;
    tick();
    tick();
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++;
    if (gnt !== 4'b0000 || w_en !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: gnt=%b w_en=%b ready=%b, want 0000/0/0000", gnt, w_en, req_ready);
    end
    tick();
    req_valid = 4'b0001;
    tick();
    #2;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_pre_grant: gnt=%b want 0001", gnt);
    end
    wrst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || w_en !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: gnt=%b w_en=%b ready=%b, want 0000/0/0000", gnt, w_en, req_ready);
    end
    tick();
    wrst = 1'b0;
    req_valid = 4'b1010;
    #4;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rel_idle: gnt=%b want 0000", gnt);
    end
    tick();
    #4;
    checks++;
    if (gnt !== 4'b0010 || req_ready !== 4'b0010 || w_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_arb: gnt=%b ready=%b w_en=%b, want 0010/0010/1", gnt, req_ready, w_en);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single_burst();
    logic [3:0] g_tab [7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    logic       w_tab [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int d = 1;
    do_reset();
    req_valid = 4'b0100;
    for (int c = 0; c < 7; c++) begin
      req_data[2*DW +: DW] = DW'(d);
      #4;
      checks++;
      if (gnt !== g_tab[c] || w_en !== w_tab[c]) begin
        errors++;
        $display("FAIL single_c%0d: gnt=%b w_en=%b, want %b/%b", c, gnt, w_en, g_tab[c], w_tab[c]);
      end
      if (w_tab[c]) begin
        checks++;
        if (data_in !== DW'(d)) begin
          errors++;
          $display("FAIL single_data_c%0d: data_in=%0d want %0d", c, data_in, d);
        end
        d++;
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 22; c++) begin
      want = (c % 5 == 0) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
      #4;
      checks++;
      if (gnt !== want || w_en !== (want != 4'b0000)) begin
        errors++;
        $display("FAIL rr_c%0d: gnt=%b w_en=%b, want %b/%b", c, gnt, w_en, want, want != 4'b0000);
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_full_stall();
    int writes = 0;
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      full = (c >= 3 && c <= 5);
      #4;
      if (w_en) writes++;
      if (full) begin
        checks++;
        if (w_en !== 1'b0 || req_ready !== 4'b0000 || gnt !== 4'b0001) begin
          errors++;
          $display("FAIL stall_c%0d: w_en=%b ready=%b gnt=%b, want 0/0000/0001", c, w_en, req_ready, gnt);
        end
      end
      tick();
    end
    full = 1'b0;
    checks++;
    if (writes != BL) begin
      errors++;
      $display("FAIL stall_writes: got %0d want %0d", writes, BL);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_early_release();
    logic [3:0] g_tab [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
    logic       w_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 3) ? 4'b1010 : 4'b1000;
      #4;
      checks++;
      if (gnt !== g_tab[c] || w_en !== w_tab[c]) begin
        errors++;
        $display("FAIL release_c%0d: gnt=%b w_en=%b, want %b/%b", c, gnt, w_en, g_tab[c], w_tab[c]);
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] want;
    do_reset();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b1001;
    for (int c = 2; c < 9; c++) begin
      want = (c == 2 || c == 7) ? 4'b0000 : ((c < 7) ? 4'b1000 : 4'b0001);
      #4;
      checks++;
      if (gnt !== want) begin
        errors++;
        $display("FAIL wrap_c%0d: gnt=%b want %b", c, gnt, want);
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] eg, er;
    logic       ew;
    logic [DW-1:0] ed;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
      full     = ($urandom_range(0, 3) == 0);
      req_data = {$urandom, $urandom};
      wrst     = ($urandom_range(0, 149) == 0);
      #4;
      eg = exp_gnt();
      er = exp_ready();
      ew = exp_wen();
      checks++;
      if (gnt !== eg || req_ready !== er || w_en !== ew) begin
        errors++;
        $display("FAIL rand_c%0d: gnt=%b ready=%b w_en=%b, want %b/%b/%b", c, gnt, req_ready, w_en, eg, er, ew);
      end
      if (ew) begin
        ed = req_data[m_owner*DW +: DW];
        checks++;
        if (data_in !== ed) begin
          errors++;
          $display("FAIL rand_data_c%0d: data_in=%h want %h", c, data_in, ed);
        end
      end
      tick();
    end
    wrst = 1'b0;
    req_valid = 4'b0000;
    full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_ptr_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
